// File: rtl/hex_scroll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hex_scroll_pkg                                               |
// | Description : Shared definitions for the HEX5..HEX0 scrolling-message     |
// |               sequencer: 2-bit character codes, sequencer state encoding  |
// |               and the modulo-length index helper used by the window mux.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hex_scroll_pkg;

    // Character codes understood by the per-digit char-to-segment decoders
    localparam logic [1:0] CHAR_D     = 2'b00;
    localparam logic [1:0] CHAR_E     = 2'b01;
    localparam logic [1:0] CHAR_L     = 2'b10;
    localparam logic [1:0] CHAR_BLANK = 2'b11;

    // Sequencer states; the numeric values are visible on the state port
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } scroll_state_t;

    // Message index for a window digit: wraps v into 0..n-1.
    // n==0 never selects a real entry (the caller blanks the window).
    function automatic int unsigned mod_idx(input int unsigned v, input int unsigned n);
        return (n == 0) ? 0 : (v % n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_scroll_ctrl_rate_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rate_divider                                                 |
// | Description : Scroll-rate divider. Counts 0..DIV-1 (DIV = CLK_HZ/STEP_HZ)  |
// |               while en is high and asserts tick on the DIV-1 count, after  |
// |               which the count wraps to 0. sync_clr restarts the count.     |
// | Ports       : CLOCK_50 - clock, rising edge                                |
// |               clr      - asynchronous active-low reset                     |
// |               en       - count enable (held while scrolling)               |
// |               sync_clr - synchronous restart to 0 (wins over en)           |
// |               tick     - high for one cycle each DIV enabled cycles        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rate_divider #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 1
) (
    input  logic CLOCK_50,
    input  logic clr,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int c_DIV   = CLK_HZ / STEP_HZ;
    localparam int c_CNT_W = $clog2(c_DIV);

    logic [c_CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == c_CNT_W'(c_DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hex_scroll_ctrl                                              |
// | Description : Sequencer for the six-digit HEX5..HEX0 scrolling message.   |
// |               Holds a writable buffer of char codes plus a length, steps  |
// |               a rotation pointer at STEP_HZ while running (or on a step   |
// |               pulse while paused) and drives a registered 6-char window.  |
// | Ports       : CLOCK_50 - clock;  clr - async active-low reset              |
// |               run      - 1 scroll / 0 pause;  step - single advance pulse  |
// |               dir      - 1 = scroll backwards (SCROLL_REV_EN builds only)  |
// |               wr_en/wr_addr/wr_data - message entry write                 |
// |               len_we/len_in - message length load (saturates at depth)    |
// |               win  - [11:10]=HEX5 .. [1:0]=HEX0;  pos - rotation pointer   |
// |               wrap - pointer wrapped;  wr_err - write rejected while RUN   |
// |               state - IDLE=0 RUN=1 PAUSE=2                                 |
// | Config      : `define SCROLL_REV_EN adds the dir input (reverse scroll).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int STEP_HZ   = 1,
    parameter int MSG_DEPTH = 8,
    parameter int CHAR_W    = 2
) (
    input  logic                           CLOCK_50,
    input  logic                           clr,
    input  logic                           run,
    input  logic                           step,
`ifdef SCROLL_REV_EN
    input  logic                           dir,
`endif
    input  logic                           wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
    input  logic [CHAR_W-1:0]              wr_data,
    input  logic                           len_we,
    input  logic [$clog2(MSG_DEPTH):0]     len_in,
    output logic [6*CHAR_W-1:0]            win,
    output logic [$clog2(MSG_DEPTH)-1:0]   pos,
    output logic                           wrap,
    output logic                           wr_err,
    output logic [1:0]                     state
);

    localparam int                  c_ADDR_W = $clog2(MSG_DEPTH);
    localparam int                  c_DIGITS = 6;
    localparam logic [c_ADDR_W:0]   c_DEPTH_L = (c_ADDR_W + 1)'(MSG_DEPTH);

    scroll_state_t          r_state;
    logic [CHAR_W-1:0]      r_msg [MSG_DEPTH];
    logic [c_ADDR_W:0]      r_len;

    logic                   w_dir;
    logic                   w_busy;
    logic                   w_tick;
    logic                   w_wr_acc;
    logic                   w_len_acc;
    logic [c_ADDR_W:0]      w_len_sat;
    logic                   w_go_idle;
    logic                   w_enter_run;
    logic                   w_adv;
    logic [c_ADDR_W-1:0]    w_len_m1;
    logic                   w_last;
    logic [c_ADDR_W-1:0]    w_pos_inc;
    logic [c_ADDR_W-1:0]    w_pos_dec;
    logic [6*CHAR_W-1:0]    w_win;

`ifdef SCROLL_REV_EN
    assign w_dir = dir;
`else
    assign w_dir = 1'b0;
`endif

    assign state = r_state;

    // Buffer and length are frozen while scrolling; attempts are flagged instead
    assign w_busy    = (r_state == ST_RUN);
    assign w_wr_acc  = wr_en  && !w_busy;
    assign w_len_acc = len_we && !w_busy;
    assign w_len_sat = (len_in > c_DEPTH_L) ? c_DEPTH_L : len_in;
    assign w_go_idle = w_len_acc && (w_len_sat == '0);

    // Divider restarts on the same edge that enters RUN, so the first
    // advance lands a full DIV cycles later
    assign w_enter_run = run && !w_go_idle &&
                         (((r_state == ST_IDLE) && (r_len != '0)) || (r_state == ST_PAUSE));

    // A step during RUN is ignored, so tick+step can never double-advance
    assign w_adv = (w_busy && w_tick) || ((r_state == ST_PAUSE) && step);

    // Length is never 0 outside IDLE, where no advance happens
    assign w_len_m1  = c_ADDR_W'(r_len - 1'b1);
    assign w_last    = (pos == w_len_m1);
    assign w_pos_inc = w_last ? '0 : pos + 1'b1;
    assign w_pos_dec = (pos == '0) ? w_len_m1 : pos - 1'b1;

    rate_divider #(
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ)
    ) u_rate_divider (
        .CLOCK_50 (CLOCK_50),
        .clr      (clr),
        .en       (w_busy),
        .sync_clr (w_enter_run),
        .tick     (w_tick)
    );

    // Window mux: digit k (HEX5 first) shows entry (pos+k) mod len
    always_comb begin
        w_win = '0;
        for (int k = 0; k < c_DIGITS; k++) begin
            if (r_len == '0) begin
                w_win[(c_DIGITS-1-k)*CHAR_W +: CHAR_W] = CHAR_W'(CHAR_BLANK);
            end else begin
                w_win[(c_DIGITS-1-k)*CHAR_W +: CHAR_W] =
                    r_msg[c_ADDR_W'(mod_idx(32'(pos) + k, 32'(r_len)))];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            pos     <= '0;
            win     <= {c_DIGITS{CHAR_W'(CHAR_BLANK)}};
            wrap    <= 1'b0;
            wr_err  <= 1'b0;
            for (int i = 0; i < MSG_DEPTH; i++) begin
                r_msg[i] <= CHAR_W'(CHAR_BLANK);
            end
        end else begin
            win    <= w_win;
            wrap   <= 1'b0;
            wr_err <= w_busy && (wr_en || len_we);

            if (w_adv) begin
                pos  <= w_dir ? w_pos_dec : w_pos_inc;
                wrap <= w_dir ? (pos == '0) : w_last;
            end

            case (r_state)
                ST_IDLE:  if (run && (r_len != '0)) r_state <= ST_RUN;
                ST_RUN:   if (!run)                 r_state <= ST_PAUSE;
                ST_PAUSE: if (run)                  r_state <= ST_RUN;
                default:                            r_state <= ST_IDLE;
            endcase

            if (w_wr_acc) begin
                r_msg[wr_addr] <= wr_data;
            end

            // Loading a length restarts the message; a zero length also stops it
            if (w_len_acc) begin
                r_len <= w_len_sat;
                pos   <= '0;
                if (w_go_idle) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hex_scroll_ctrl                                           |
// | Description : Self-checking bench for hex_scroll_ctrl (DIV = 10). A       |
// |               behavioural model predicts every output each cycle; directed|
// |               literal checks pin the model, then random traffic follows.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hex_scroll_ctrl;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        dir = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [1:0]  wr_data = '0;
    logic        len_we = 1'b0;
    logic [3:0]  len_in = '0;
    logic [11:0] win;
    logic [2:0]  pos;
    logic        wrap;
    logic        wr_err;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b1;

    always #5 clk = ~clk;

    hex_scroll_ctrl #(
        .CLK_HZ    (10),
        .STEP_HZ   (1),
        .MSG_DEPTH (8),
        .CHAR_W    (2)
    ) dut (
        .CLOCK_50 (clk),
        .clr      (clr),
        .run      (run),
        .step     (step),
`ifdef SCROLL_REV_EN
        .dir      (dir),
`endif
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .len_we   (len_we),
        .len_in   (len_in),
        .win      (win),
        .pos      (pos),
        .wrap     (wrap),
        .wr_err   (wr_err),
        .state    (state)
    );

    // ---------------- behavioural model ----------------
    logic [1:0]  m_msg [8];
    int          m_len, m_pos, m_st, m_since;
    logic [11:0] m_win;
    bit          m_wrap, m_err;

    function automatic logic [11:0] model_win(int p, int l);
        logic [11:0] w;
        w = 12'hFFF;
        if (l != 0)
            for (int k = 0; k < 6; k++) w[11-2*k -: 2] = m_msg[(p + k) % l];
        return w;
    endfunction

    always @(posedge clk or negedge clr) begin : p_model
        int npos, nst, lv;
        bit tick, adv, acc;
        if (!clr) begin
            for (int i = 0; i < 8; i++) m_msg[i] = 2'b11;
            m_len = 0; m_pos = 0; m_st = 0; m_since = 0;
            m_win = 12'hFFF; m_wrap = 1'b0; m_err = 1'b0;
        end else begin
            m_win  = model_win(m_pos, m_len);
            tick   = (m_st == 1) && ((m_since % DIV) == DIV - 1);
            adv    = ((m_st == 1) && tick) || ((m_st == 2) && step);
            acc    = (m_st != 1);
            m_err  = (m_st == 1) && (wr_en || len_we);
            m_wrap = 1'b0;
            npos   = m_pos;
            nst    = m_st;
            if (adv) begin
                if (dir) begin
                    if (m_pos == 0) begin npos = m_len - 1; m_wrap = 1'b1; end
                    else npos = m_pos - 1;
                end else begin
                    if (m_pos == m_len - 1) begin npos = 0; m_wrap = 1'b1; end
                    else npos = m_pos + 1;
                end
            end
            if (m_st == 0 && run && m_len != 0) nst = 1;
            else if (m_st == 1 && !run)         nst = 2;
            else if (m_st == 2 && run)          nst = 1;
            if (acc && wr_en) m_msg[wr_addr] = wr_data;
            if (acc && len_we) begin
                lv    = (int'(len_in) > 8) ? 8 : int'(len_in);
                m_len = lv;
                npos  = 0;
                if (lv == 0) nst = 0;
            end
            if (m_st == 1) m_since++;
            if (nst == 1 && m_st != 1) m_since = 0;
            m_pos = npos;
            m_st  = nst;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (clr && cmp_en) begin
            n_checks++;
            if (win !== m_win || pos !== 3'(m_pos) || wrap !== m_wrap ||
                wr_err !== m_err || state !== 2'(m_st)) begin
                n_fail++;
                $display("FAIL cmp t=%0t win=%h/%h pos=%0d/%0d wrap=%b/%b wr_err=%b/%b state=%0d/%0d (got/expected)",
                         $time, win, m_win, pos, m_pos, wrap, m_wrap, wr_err, m_err, state, m_st);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load_len(input logic [3:0] l);
        len_we = 1'b1; len_in = l;
        cyc();
        len_we = 1'b0;
    endtask

    task automatic write_ent(input logic [2:0] a, input logic [1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    // Waits (bounded) until the model says the next edge carries a tick
    task automatic wait_tick_edge();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_st == 1 && (m_since % DIV) == DIV - 1) begin found = 1'b1; break; end
            cyc();
        end
        check("tick_wait", 32'(found), 32'd1);
    endtask

    initial begin
        repeat (2) cyc();
        clr = 1'b1;
        cyc();
        // 1. reset values, run with len=0 stays idle
        check("rst_win", 32'(win), 32'h0FFF);
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        run = 1'b1;
        repeat (3) cyc();
        check("idle_len0", 32'(state), 32'd0);
        run = 1'b0;

        // 2. D E L _ _ _ _ _, len 8, scroll
        write_ent(3'd0, 2'b00);
        write_ent(3'd1, 2'b01);
        write_ent(3'd2, 2'b10);
        for (int a = 3; a < 8; a++) write_ent(3'(a), 2'b11);
        load_len(4'd8);
        cyc();
        check("win_start", 32'(win), 32'h01BF);
        run = 1'b1;
        cyc();
        check("run_entry", 32'(state), 32'd1);
        repeat (9) cyc();
        check("pos_before_tick", 32'(pos), 32'd0);
        cyc();
        check("pos_first_tick", 32'(pos), 32'd1);
        cyc();
        check("win_pos1", 32'(win), 32'h06FF);
        repeat (69) cyc();
        check("pos_wrap", 32'(pos), 32'd0);
        check("wrap_pulse", 32'(wrap), 32'd1);

        // 3. write rejected in RUN, pause and single-step
        write_ent(3'd0, 2'b11);
        check("wr_err_pulse", 32'(wr_err), 32'd1);
        run = 1'b0;
        cyc();
        check("pause", 32'(state), 32'd2);
        repeat (3) begin
            step = 1'b1; cyc(); step = 1'b0; cyc();
        end
        check("step3", 32'(pos), 32'd3);
        repeat (15) cyc();
        check("pause_hold", 32'(pos), 32'd3);

        // 4. length reloads
        load_len(4'd3);
        cyc();
        check("win_len3", 32'(win), 32'h0186);
        load_len(4'd15);
        cyc();
        check("win_len_sat", 32'(win), 32'h01BF);
        load_len(4'd0);
        check("len0_idle", 32'(state), 32'd0);
        cyc();
        check("len0_win", 32'(win), 32'h0FFF);

        // 5. tick with run falling; tick with step
        load_len(4'd8);
        run = 1'b1;
        cyc();
        wait_tick_edge();
        run = 1'b0;
        cyc();
        check("tick_runfall_pos", 32'(pos), 32'd1);
        check("tick_runfall_st", 32'(state), 32'd2);
        run = 1'b1;
        cyc();
        wait_tick_edge();
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("tick_step_pos", 32'(pos), 32'd2);
        run = 1'b0;
        cyc();

`ifdef SCROLL_REV_EN
        // 6a. reverse step from 0 wraps to len-1
        load_len(4'd8);
        dir = 1'b1; step = 1'b1;
        cyc();
        step = 1'b0; dir = 1'b0;
        check("rev_pos", 32'(pos), 32'd7);
        check("rev_wrap", 32'(wrap), 32'd1);
`endif

        // 6b. asynchronous reset mid-RUN
        run = 1'b1;
        repeat (15) cyc();
        #3 clr = 1'b0;
        #1;
        check("clr_win", 32'(win), 32'h0FFF);
        check("clr_pos", 32'(pos), 32'd0);
        check("clr_state", 32'(state), 32'd0);
        check("clr_flags", {30'd0, wrap, wr_err}, 32'd0);
        cyc();
        clr = 1'b1;
        run = 1'b0;
        cyc();

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            step    = ($urandom_range(0, 5) == 0);
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_addr = 3'($urandom);
            wr_data = 2'($urandom);
            len_we  = ($urandom_range(0, 24) == 0);
            len_in  = 4'($urandom_range(0, 15));
`ifdef SCROLL_REV_EN
            dir     = 1'($urandom);
`endif
            cyc();
        end
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
